spi_controller: RTL

- SPI initiator (mode 0, write frames) that drives the existing SPI peripheral register block from the system clock domain.
- Accepts a single-cycle command (rw bit, 7-bit address, 8-bit data), serialises it as one 16-bit frame MSB-first, and reports completion.
- Sits on the chip or test side of the SCLK/nCS/MOSI link; used for bring-up and loopback testing of the peripheral's en_reg/en_pwm/duty-cycle registers.

---
 rtl/spi_controller.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: serialises one 16-bit {rw,addr,wdata} frame, MSB first.
// Ports: clk, nrst (sync, active-low); start/rw/addr/wdata command in;
//        busy, done status out; SCLK, nCS, MOSI serial link out (all registered).
module spi_controller #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned CS_SETUP   = 2,
    parameter int unsigned CS_HOLD    = 4,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       SCLK,
    output logic       nCS,
    output logic       MOSI
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] sr_q, sr_d;
    logic [7:0]  div_q, div_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        sclk_q, sclk_d;
    logic        ncs_q, ncs_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        cnt_d     = cnt_q;
        sclk_d    = sclk_q;
        ncs_d     = ncs_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SETUP;
                    sr_d      = {rw, addr, wdata};
                    div_d     = '0;
                    bit_cnt_d = '0;
                    cnt_d     = '0;
                    sclk_d    = 1'b0;
                    ncs_d     = 1'b0;
                    mosi_d    = rw;
                    busy_d    = 1'b1;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = SHIFT;
                    div_d   = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    // Falling edge: advance to the next bit.
                    if (sclk_q) begin
                        if (bit_cnt_q != 5'd16) begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                        if (bit_cnt_q == 5'd15) begin
                            // Last fall: keep bit 0 on MOSI through HOLD.
                            state_d = HOLD;
                            cnt_d   = '0;
                        end else begin
                            sr_d   = {sr_q[14:0], 1'b0};
                            mosi_d = sr_q[14];
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    ncs_d   = 1'b1;
                    mosi_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            div_q     <= '0;
            bit_cnt_q <= '0;
            cnt_q     <= '0;
            sclk_q    <= 1'b0;
            ncs_q     <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            cnt_q     <= cnt_d;
            sclk_q    <= sclk_d;
            ncs_q     <= ncs_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign SCLK = sclk_q;
    assign nCS  = ncs_q;
    assign MOSI = mosi_q;

endmodule
